// File: rtl/cpu_bank_reg_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bank_reg_multiport
//  Brief    : Multi-port register file with registered reads, optional
//             write-to-read bypass, optional zero register and busy scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bank_reg_multiport #(
    parameter  int REG_WIDTH = 32,
    parameter  int NUM_REGS  = 32,
    parameter  int NUM_RD    = 2,
    parameter  int NUM_WR    = 1,
    parameter  int BYPASS    = 1,
    parameter  int ZERO_REG  = 1,
    localparam int c_ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_RD*c_ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_pending,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*c_ADDR_W-1:0]    wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0]   wr_data,
    input  logic                          rsv_en,
    input  logic [c_ADDR_W-1:0]           rsv_addr,
    output logic [NUM_REGS-1:0]           busy
);

    // An address is usable when it exists and is not the hardwired zero register.
    function automatic logic f_addr_ok(input logic [c_ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;

    logic [NUM_WR-1:0]    w_wr_ok;
    logic                 w_rsv_ok;
    logic [NUM_REGS-1:0]  w_busy_clr;
    logic [NUM_REGS-1:0]  w_busy_next;

    // Writebacks clear first, then the reservation sets: the new owner wins.
    always_comb begin
        w_wr_ok    = '0;
        w_busy_clr = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = wr_en[j] && f_addr_ok(wr_addr[j*c_ADDR_W +: c_ADDR_W]);
            if (w_wr_ok[j]) begin
                w_busy_clr[wr_addr[j*c_ADDR_W +: c_ADDR_W]] = 1'b0;
            end
        end
        w_rsv_ok    = rsv_en && f_addr_ok(rsv_addr);
        w_busy_next = w_busy_clr;
        if (w_rsv_ok) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
    end

    // Ascending port order with non-blocking updates lets the highest port win.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[wr_addr[j*c_ADDR_W +: c_ADDR_W]] <= wr_data[j*REG_WIDTH +: REG_WIDTH];
                end
            end
            r_busy <= w_busy_next;
        end
    end

    assign busy = r_busy;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [c_ADDR_W-1:0]  w_addr;
            logic                 w_addr_ok;
            logic [REG_WIDTH-1:0] w_data;
            logic                 w_pend;
            logic [REG_WIDTH-1:0] r_data;
            logic                 r_pend;

            assign w_addr    = rd_addr[i*c_ADDR_W +: c_ADDR_W];
            assign w_addr_ok = f_addr_ok(w_addr);

            always_comb begin
                w_data = '0;
                w_pend = 1'b0;
                if (w_addr_ok) begin
                    w_data = r_regs[w_addr];
                    w_pend = (BYPASS != 0) ? w_busy_clr[w_addr] : r_busy[w_addr];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NUM_WR; j++) begin
                            if (w_wr_ok[j] && (wr_addr[j*c_ADDR_W +: c_ADDR_W] == w_addr)) begin
                                w_data = wr_data[j*REG_WIDTH +: REG_WIDTH];
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_data <= '0;
                    r_pend <= 1'b0;
                end else begin
                    r_data <= w_data;
                    r_pend <= w_pend;
                end
            end

            assign rd_data[i*REG_WIDTH +: REG_WIDTH] = r_data;
            assign rd_pending[i]                     = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_bank_reg_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bank_reg_multiport
//  Brief    : Directed bench; dut_a = bypass/zero-reg/32 regs, dut_b =
//             no bypass/no zero-reg/20 regs, sharing one stimulus set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bank_reg_multiport;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  pend_a, pend_b;
    logic [31:0] busy_a;
    logic [19:0] busy_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    cpu_bank_reg_multiport #(
        .REG_WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
    ) dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_pending(pend_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_a)
    );

    cpu_bank_reg_multiport #(
        .REG_WIDTH(32), .NUM_REGS(20), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(0)
    ) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 2'b00;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rd_addr = '0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            tick();
            n_total++;
            if ({rd_data_a, pend_a, busy_a} !== '0)
                $display("FAIL reset_a addr=%0d got data=%h pend=%b busy=%h expected all 0", a, rd_data_a, pend_a, busy_a);
            else n_pass++;
            n_total++;
            if ({rd_data_b, pend_b, busy_b} !== '0)
                $display("FAIL reset_b addr=%0d got data=%h pend=%b busy=%h expected all 0", a, rd_data_b, pend_b, busy_b);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd5, 5'd5};
        tick();
        n_total++;
        if (rd_data_a !== {32'hDEADBEEF, 32'hDEADBEEF})
            $display("FAIL bypass_a got %h expected %h", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
        else n_pass++;
        n_total++;
        if (rd_data_b !== 64'h0)
            $display("FAIL nobypass_same_cycle got %h expected 0", rd_data_b);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (rd_data_b !== {32'hDEADBEEF, 32'hDEADBEEF})
            $display("FAIL nobypass_next_cycle got %h expected %h", rd_data_b, {32'hDEADBEEF, 32'hDEADBEEF});
        else n_pass++;
    endtask

    task automatic test_multi_write();
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd7};
        tick();
        n_total++;
        if (rd_data_a[31:0] !== 32'h22)
            $display("FAIL multi_write_bypass got %h expected 00000022", rd_data_a[31:0]);
        else n_pass++;
        n_total++;
        if (rd_data_b[31:0] !== 32'h0)
            $display("FAIL multi_write_old got %h expected 00000000", rd_data_b[31:0]);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (rd_data_a !== {32'h22, 32'h22})
            $display("FAIL multi_write_a got %h expected %h", rd_data_a, {32'h22, 32'h22});
        else n_pass++;
        n_total++;
        if (rd_data_b !== {32'h22, 32'h22})
            $display("FAIL multi_write_b got %h expected %h", rd_data_b, {32'h22, 32'h22});
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd0};
        wr_data  = {32'h0, 32'hFFFF_FFFF};
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rd_addr  = {5'd0, 5'd0};
        tick();
        n_total++;
        if (rd_data_a !== 64'h0 || busy_a[0] !== 1'b0)
            $display("FAIL zero_reg_same got data=%h busy0=%b expected 0/0", rd_data_a, busy_a[0]);
        else n_pass++;
        n_total++;
        if (busy_b[0] !== 1'b1)
            $display("FAIL zero_reg_off_rsv got busy0=%b expected 1", busy_b[0]);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (rd_data_a !== 64'h0 || pend_a !== 2'b00)
            $display("FAIL zero_reg_read got data=%h pend=%b expected 0/00", rd_data_a, pend_a);
        else n_pass++;
        n_total++;
        if (rd_data_b[31:0] !== 32'hFFFF_FFFF || pend_b[0] !== 1'b1)
            $display("FAIL zero_reg_off_read got data=%h pend=%b expected ffffffff/1", rd_data_b[31:0], pend_b[0]);
        else n_pass++;
        wr_en   = 2'b01;
        wr_data = '0;
        tick();
        idle_inputs();
        n_total++;
        if (busy_b[0] !== 1'b0)
            $display("FAIL zero_reg_off_clear got busy0=%b expected 0", busy_b[0]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        rd_addr  = {5'd3, 5'd3};
        tick();
        n_total++;
        if (busy_a !== 32'h8 || pend_a !== 2'b00)
            $display("FAIL rsv_set got busy=%h pend=%b expected 00000008/00", busy_a, pend_a);
        else n_pass++;
        rsv_en = 1'b0;
        tick();
        n_total++;
        if (pend_a !== 2'b11 || pend_b !== 2'b11)
            $display("FAIL rsv_pending got a=%b b=%b expected 11/11", pend_a, pend_b);
        else n_pass++;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd3};
        wr_data  = {32'h0, 32'h33};
        rsv_en   = 1'b1;
        tick();
        n_total++;
        if (busy_a[3] !== 1'b1 || busy_b[3] !== 1'b1)
            $display("FAIL rsv_wins got a=%b b=%b expected 1/1", busy_a[3], busy_b[3]);
        else n_pass++;
        n_total++;
        if (pend_a !== 2'b00 || pend_b !== 2'b11)
            $display("FAIL rsv_wins_pending got a=%b b=%b expected 00/11", pend_a, pend_b);
        else n_pass++;
        rsv_en = 1'b0;
        tick();
        n_total++;
        if (busy_a !== 32'h0 || busy_b !== 20'h0)
            $display("FAIL wr_clear got a=%h b=%h expected 0/0", busy_a, busy_b);
        else n_pass++;
        n_total++;
        if (pend_a !== 2'b00 || pend_b !== 2'b11)
            $display("FAIL wr_clear_pending got a=%b b=%b expected 00/11", pend_a, pend_b);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (pend_b !== 2'b00 || rd_data_b[31:0] !== 32'h33)
            $display("FAIL wr_clear_after got pend=%b data=%h expected 00/00000033", pend_b, rd_data_b[31:0]);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd25};
        wr_data  = {32'h0, 32'hAB};
        rsv_en   = 1'b1;
        rsv_addr = 5'd25;
        rd_addr  = {5'd19, 5'd25};
        tick();
        n_total++;
        if (rd_data_b !== 64'h0 || pend_b !== 2'b00 || busy_b !== 20'h0)
            $display("FAIL oor_b got data=%h pend=%b busy=%h expected 0/00/0", rd_data_b, pend_b, busy_b);
        else n_pass++;
        n_total++;
        if (rd_data_a[31:0] !== 32'hAB || busy_a !== 32'h0200_0000)
            $display("FAIL oor_a got data=%h busy=%h expected 000000ab/02000000", rd_data_a[31:0], busy_a);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (rd_data_b[31:0] !== 32'h0 || pend_a[0] !== 1'b1)
            $display("FAIL oor_after got b=%h pend_a=%b expected 0/1", rd_data_b[31:0], pend_a[0]);
        else n_pass++;
    endtask

    task automatic test_reset_dominates();
        reset    = 1'b1;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd9};
        wr_data  = {32'h0, 32'h55};
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        rd_addr  = {5'd5, 5'd9};
        tick();
        n_total++;
        if ({rd_data_a, pend_a, busy_a} !== '0 || {rd_data_b, pend_b, busy_b} !== '0)
            $display("FAIL reset_dom got a=%h/%b/%h b=%h/%b/%h expected all 0",
                     rd_data_a, pend_a, busy_a, rd_data_b, pend_b, busy_b);
        else n_pass++;
        reset = 1'b0;
        idle_inputs();
        tick();
        n_total++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0)
            $display("FAIL reset_dom_regs got a=%h b=%h expected 0/0", rd_data_a, rd_data_b);
        else n_pass++;
        n_total++;
        if (busy_a !== 32'h0 || busy_b !== 20'h0)
            $display("FAIL reset_dom_busy got a=%h b=%h expected 0/0", busy_a, busy_b);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_multi_write();
        test_zero_reg();
        test_scoreboard();
        test_out_of_range();
        test_reset_dominates();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
